// File: rtl/mem_port_arbiter_if.sv
// Data-memory port bundle between the arbiter (master) and data memory (slave).
// The arbiter drives the request and its operand fields; memory answers with mem_ack.
interface mem_port_arbiter_if #(
  parameter int ROB_W = 5,
  parameter int REG_W = 5
);
  logic             mem_req;
  logic             mem_we;
  logic [REG_W-1:0] mem_ra_addr;
  logic [REG_W-1:0] mem_rt_addr;
  logic [ROB_W-1:0] mem_rob_addr;
  logic             mem_ack;

  modport master (
    output mem_req, mem_we, mem_ra_addr, mem_rt_addr, mem_rob_addr,
    input  mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_ra_addr, mem_rt_addr, mem_rob_addr,
    output mem_ack
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single data-memory port between the store buffer head and
// the load buffer head. Loads win by default; a store at the ROB head wins
// when the store buffer is full, when loads have starved it, or when no load
// is waiting. One operation is outstanding at a time; completion is reported
// to the ROB as a one-cycle done pulse.
module mem_port_arbiter #(
  parameter int ROB_W        = 5,
  parameter int REG_W        = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  // store buffer head
  input  logic             st_valid,
  input  logic [ROB_W-1:0] st_rob_addr,
  input  logic [REG_W-1:0] st_ra_addr,
  input  logic [REG_W-1:0] st_rt_addr,
  input  logic             st_full,
  output logic             st_pop,
  // load buffer head
  input  logic             ld_valid,
  input  logic [ROB_W-1:0] ld_rob_addr,
  input  logic [REG_W-1:0] ld_ra_addr,
  input  logic [REG_W-1:0] ld_rt_addr,
  output logic             ld_pop,
  // ROB
  input  logic [ROB_W-1:0] rob_head,
  input  logic             flush,
  // data memory
  mem_port_arbiter_if.master mem,
  // completion
  output logic             done_valid,
  output logic [ROB_W-1:0] done_rob_addr,
  output logic             done_is_store
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {IDLE, REQ} state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [REG_W-1:0]      ra_q, ra_d;
  logic [REG_W-1:0]      rt_q, rt_d;
  logic [ROB_W-1:0]      rob_q, rob_d;
  logic                  squashed_q, squashed_d;
  logic [STARVE_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic                  done_valid_q, done_valid_d;
  logic [ROB_W-1:0]      done_rob_q, done_rob_d;
  logic                  done_is_store_q, done_is_store_d;

  logic st_eligible;
  logic st_win;

  // A store may only go to memory once it is the oldest instruction in flight.
  assign st_eligible = st_valid && (st_rob_addr == rob_head);
  assign st_win      = st_eligible &&
                       (st_full || (starve_cnt_q == STARVE_W'(STARVE_LIMIT)) || !ld_valid);

  // Grant decision, pops and next-state computation.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d         = state_q;
    we_d            = we_q;
    ra_d            = ra_q;
    rt_d            = rt_q;
    rob_d           = rob_q;
    squashed_d      = squashed_q;
    starve_cnt_d    = starve_cnt_q;
    done_valid_d    = 1'b0;
    done_rob_d      = done_rob_q;
    done_is_store_d = done_is_store_q;
    st_pop          = 1'b0;
    ld_pop          = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Pops are gated by rst so a buffer never advances into a reset.
        if (!flush && !rst) begin
          if (st_win) begin
            st_pop       = 1'b1;
            we_d         = 1'b1;
            ra_d         = st_ra_addr;
            rt_d         = st_rt_addr;
            rob_d        = st_rob_addr;
            squashed_d   = 1'b0;
            starve_cnt_d = '0;
            state_d      = REQ;
          end else if (ld_valid) begin
            ld_pop     = 1'b1;
            we_d       = 1'b0;
            ra_d       = ld_ra_addr;
            rt_d       = ld_rt_addr;
            rob_d      = ld_rob_addr;
            squashed_d = 1'b0;
            if (st_eligible && (starve_cnt_q != STARVE_W'(STARVE_LIMIT)))
              starve_cnt_d = starve_cnt_q + 1'b1;
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        // A squashed load still finishes its memory access but is not reported;
        // stores are always older than any mispredict and are never squashed.
        if (flush && !we_q)
          squashed_d = 1'b1;
        if (mem.mem_ack) begin
          state_d         = IDLE;
          done_valid_d    = we_q || !(squashed_q || flush);
          done_rob_d      = rob_q;
          done_is_store_d = we_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking assignment so every register samples pre-edge values, regardless of statement order.
    if (rst) begin
      state_q         <= IDLE;
      we_q            <= 1'b0;
      ra_q            <= '0;
      rt_q            <= '0;
      rob_q           <= '0;
      squashed_q      <= 1'b0;
      starve_cnt_q    <= '0;
      done_valid_q    <= 1'b0;
      done_rob_q      <= '0;
      done_is_store_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      we_q            <= we_d;
      ra_q            <= ra_d;
      rt_q            <= rt_d;
      rob_q           <= rob_d;
      squashed_q      <= squashed_d;
      starve_cnt_q    <= starve_cnt_d;
      done_valid_q    <= done_valid_d;
      done_rob_q      <= done_rob_d;
      done_is_store_q <= done_is_store_d;
    end
  end

  assign mem.mem_req      = (state_q == REQ);
  assign mem.mem_we       = we_q;
  assign mem.mem_ra_addr  = ra_q;
  assign mem.mem_rt_addr  = rt_q;
  assign mem.mem_rob_addr = rob_q;

  assign done_valid    = done_valid_q;
  assign done_rob_addr = done_rob_q;
  assign done_is_store = done_is_store_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a transaction-level model checks
// every cycle, and directed scenarios pin literal expectations.
module tb_mem_port_arbiter;
  localparam int ROB_W = 5;
  localparam int REG_W = 5;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, st_valid, st_full, ld_valid, flush;
  logic [ROB_W-1:0] st_rob_addr, ld_rob_addr, rob_head;
  logic [REG_W-1:0] st_ra_addr, st_rt_addr, ld_ra_addr, ld_rt_addr;
  logic             st_pop, ld_pop, done_valid, done_is_store;
  logic [ROB_W-1:0] done_rob_addr;

  mem_port_arbiter_if #(.ROB_W(ROB_W), .REG_W(REG_W)) mem_if ();

  mem_port_arbiter #(.ROB_W(ROB_W), .REG_W(REG_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_rob_addr(st_rob_addr), .st_ra_addr(st_ra_addr),
    .st_rt_addr(st_rt_addr), .st_full(st_full), .st_pop(st_pop),
    .ld_valid(ld_valid), .ld_rob_addr(ld_rob_addr), .ld_ra_addr(ld_ra_addr),
    .ld_rt_addr(ld_rt_addr), .ld_pop(ld_pop),
    .rob_head(rob_head), .flush(flush), .mem(mem_if),
    .done_valid(done_valid), .done_rob_addr(done_rob_addr), .done_is_store(done_is_store)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct { bit we; int rob; int ra; int rt; } op_t;

  bit  model_live = 0;
  bit  m_busy, m_squash, m_done_v, m_done_st;
  int  m_starve, m_done_rob;
  op_t m_op;
  bit  grant_log[$];

  function automatic void exp_grant(output bit sg, output bit lg);
    bit st_el;
    sg = 0;
    lg = 0;
    if (rst !== 1'b0 || m_busy || flush) return;
    st_el = st_valid && (st_rob_addr == rob_head);
    if (st_el && (st_full || m_starve >= LIMIT || !ld_valid)) sg = 1;
    else if (ld_valid) lg = 1;
  endfunction

  initial begin : model_update
    bit sg, lg, nd;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_busy = 0; m_squash = 0; m_done_v = 0; m_done_st = 0;
        m_starve = 0; m_done_rob = 0; m_op = '{0, 0, 0, 0};
        model_live = 1;
      end else if (model_live) begin
        exp_grant(sg, lg);
        nd = 0;
        if (!m_busy) begin
          if (sg) begin
            m_op = '{1, int'(st_rob_addr), int'(st_ra_addr), int'(st_rt_addr)};
            m_busy = 1; m_squash = 0; m_starve = 0;
          end else if (lg) begin
            m_op = '{0, int'(ld_rob_addr), int'(ld_ra_addr), int'(ld_rt_addr)};
            m_busy = 1; m_squash = 0;
            if (st_valid && st_rob_addr == rob_head && m_starve < LIMIT) m_starve++;
          end
        end else begin
          if (flush && !m_op.we) m_squash = 1;
          if (mem_if.mem_ack) begin
            m_busy = 0;
            nd = m_op.we || !m_squash;
            m_done_rob = m_op.rob;
            m_done_st = m_op.we;
          end
        end
        m_done_v = nd;
      end
    end
  end

  initial begin : compare
    bit sg, lg;
    forever begin
      @(negedge clk);
      if (model_live) begin
        exp_grant(sg, lg);
        check("st_pop", 32'(st_pop), 32'(sg));
        check("ld_pop", 32'(ld_pop), 32'(lg));
        if (st_pop === 1'b1) grant_log.push_back(1'b1);
        else if (ld_pop === 1'b1) grant_log.push_back(1'b0);
        check("mem_req", 32'(mem_if.mem_req), 32'(m_busy));
        if (m_busy) begin
          check("mem_we", 32'(mem_if.mem_we), 32'(m_op.we));
          check("mem_rob_addr", 32'(mem_if.mem_rob_addr), 32'(m_op.rob));
          check("mem_ra_addr", 32'(mem_if.mem_ra_addr), 32'(m_op.ra));
          check("mem_rt_addr", 32'(mem_if.mem_rt_addr), 32'(m_op.rt));
        end
        check("done_valid", 32'(done_valid), 32'(m_done_v));
        if (m_done_v) begin
          check("done_rob_addr", 32'(done_rob_addr), 32'(m_done_rob));
          check("done_is_store", 32'(done_is_store), 32'(m_done_st));
        end
      end
    end
  end

  // ---------------- memory responder ----------------
  int ack_lat   = 0;
  bit force_ack = 0;
  int req_age   = 0;

  initial begin : responder
    mem_if.mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_if.mem_req === 1'b1) begin
        mem_if.mem_ack = force_ack || (req_age == ack_lat);
        req_age++;
      end else begin
        mem_if.mem_ack = force_ack;
        req_age = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    st_valid = 0; ld_valid = 0; st_full = 0; flush = 0;
  endtask

  task automatic drain();
    idle_in();
    repeat (6) tick();
  endtask

  initial begin : stimulus
    bit seen;
    bit exp_order[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    rst = 1; idle_in();
    rob_head = '0; st_rob_addr = '0; ld_rob_addr = '0;
    st_ra_addr = '0; st_rt_addr = '0; ld_ra_addr = '0; ld_rt_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst mem_req", 32'(mem_if.mem_req), 0);
    check("rst mem_we", 32'(mem_if.mem_we), 0);
    check("rst mem_ra", 32'(mem_if.mem_ra_addr), 0);
    check("rst mem_rob", 32'(mem_if.mem_rob_addr), 0);
    check("rst done_valid", 32'(done_valid), 0);
    check("rst done_is_store", 32'(done_is_store), 0);
    check("rst pops", 32'({st_pop, ld_pop}), 0);
    check("rst starve_cnt", 32'(dut.starve_cnt_q), 0);
    tick(); rst = 0;

    // single load
    ack_lat = 0;
    ld_valid = 1; ld_rob_addr = 3; ld_ra_addr = 1; ld_rt_addr = 2;
    @(negedge clk); check("load c0 ld_pop", 32'(ld_pop), 1);
    tick(); ld_valid = 0;
    @(negedge clk); check("load c1 mem_req", 32'(mem_if.mem_req), 1);
    check("load c1 mem_we", 32'(mem_if.mem_we), 0);
    check("load c1 mem_rob", 32'(mem_if.mem_rob_addr), 3);
    tick();
    @(negedge clk); check("load c2 done_valid", 32'(done_valid), 1);
    check("load c2 done_rob", 32'(done_rob_addr), 3);
    check("load c2 done_is_store", 32'(done_is_store), 0);
    drain();

    // store gated until it reaches the ROB head
    st_valid = 1; st_rob_addr = 7; rob_head = 6; st_ra_addr = 4; st_rt_addr = 5;
    repeat (3) begin
      @(negedge clk); check("gate st_pop", 32'(st_pop), 0);
      check("gate mem_req", 32'(mem_if.mem_req), 0);
      tick();
    end
    rob_head = 7;
    @(negedge clk); check("gate head st_pop", 32'(st_pop), 1);
    tick(); st_valid = 0;
    @(negedge clk); check("gate mem_we", 32'(mem_if.mem_we), 1);
    check("gate mem_rob", 32'(mem_if.mem_rob_addr), 7);
    tick();
    @(negedge clk); check("gate done_is_store", 32'(done_is_store), 1);
    drain();

    // starvation guard: 4 loads, then the store
    grant_log.delete();
    rob_head = 9; st_valid = 1; st_rob_addr = 9; st_ra_addr = 8; st_rt_addr = 11;
    ld_valid = 1; ld_rob_addr = 10; ld_ra_addr = 12; ld_rt_addr = 13;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (st_pop) seen = 1;
      tick();
      if (seen) st_valid = 0;
    end
    drain();
    check("starve grant count", 32'(grant_log.size() >= 5), 1);
    for (int k = 0; k < 5; k++)
      if (k < grant_log.size()) check($sformatf("starve order[%0d]", k), 32'(grant_log[k]), 32'(exp_order[k]));
    check("starve_cnt cleared", 32'(dut.starve_cnt_q), 0);

    // full store buffer overrides load priority
    st_valid = 1; st_rob_addr = 12; rob_head = 12; st_full = 1;
    ld_valid = 1; ld_rob_addr = 13;
    @(negedge clk); check("full st_pop", 32'(st_pop), 1);
    check("full ld_pop", 32'(ld_pop), 0);
    tick(); st_valid = 0; st_full = 0;
    tick();
    @(negedge clk); check("full then ld_pop", 32'(ld_pop), 1);
    drain();

    // flush during a load REQ, ack three cycles later
    ack_lat = 3;
    ld_valid = 1; ld_rob_addr = 14;
    @(negedge clk); check("flush ld_pop", 32'(ld_pop), 1);
    tick(); ld_valid = 0; flush = 1;
    @(negedge clk); check("flush c1 mem_req", 32'(mem_if.mem_req), 1);
    tick(); flush = 0;
    repeat (3) begin
      @(negedge clk); check("flush hold mem_req", 32'(mem_if.mem_req), 1);
      check("flush hold mem_rob", 32'(mem_if.mem_rob_addr), 14);
      check("flush hold done_valid", 32'(done_valid), 0);
      tick();
    end
    @(negedge clk); check("flush after ack mem_req", 32'(mem_if.mem_req), 0);
    check("flush no done", 32'(done_valid), 0);
    drain();
    ack_lat = 0;

    // flush in the same cycle as the load's ack
    ld_valid = 1; ld_rob_addr = 15;
    @(negedge clk); check("flush-ack ld_pop", 32'(ld_pop), 1);
    tick(); ld_valid = 0; flush = 1;
    tick(); flush = 0;
    @(negedge clk); check("flush-ack no done", 32'(done_valid), 0);
    drain();

    // stores are not squashed by flush
    st_valid = 1; st_rob_addr = 16; rob_head = 16;
    @(negedge clk); check("st flush st_pop", 32'(st_pop), 1);
    tick(); st_valid = 0; flush = 1;
    tick(); flush = 0;
    @(negedge clk); check("st flush done_valid", 32'(done_valid), 1);
    check("st flush done_rob", 32'(done_rob_addr), 16);
    drain();

    // flush in IDLE blocks the grant for that cycle
    st_valid = 1; st_rob_addr = 17; rob_head = 17; ld_valid = 1; ld_rob_addr = 18; flush = 1;
    @(negedge clk); check("idle flush pops", 32'({st_pop, ld_pop}), 0);
    tick(); flush = 0;
    @(negedge clk); check("post flush ld_pop", 32'(ld_pop), 1);
    tick(); ld_valid = 0;
    tick();
    @(negedge clk); check("post flush st_pop", 32'(st_pop), 1);
    tick(); st_valid = 0;
    drain();

    // mem_ack while idle is ignored
    force_ack = 1;
    repeat (3) begin
      @(negedge clk); check("idle ack mem_req", 32'(mem_if.mem_req), 0);
      check("idle ack done_valid", 32'(done_valid), 0);
      tick();
    end
    force_ack = 0;
    drain();

    // reset while a request is outstanding
    ack_lat = 15;
    ld_valid = 1; ld_rob_addr = 19; ld_ra_addr = 6; ld_rt_addr = 7;
    @(negedge clk); check("rstreq ld_pop", 32'(ld_pop), 1);
    tick(); ld_valid = 0;
    @(negedge clk); check("rstreq mem_req", 32'(mem_if.mem_req), 1);
    tick(); rst = 1;
    @(negedge clk); check("rstreq pre mem_req", 32'(mem_if.mem_req), 1);
    tick();
    @(negedge clk); check("rstreq post mem_req", 32'(mem_if.mem_req), 0);
    check("rstreq mem_we", 32'(mem_if.mem_we), 0);
    check("rstreq mem_ra", 32'(mem_if.mem_ra_addr), 0);
    check("rstreq mem_rt", 32'(mem_if.mem_rt_addr), 0);
    check("rstreq mem_rob", 32'(mem_if.mem_rob_addr), 0);
    check("rstreq done_rob", 32'(done_rob_addr), 0);
    check("rstreq done_is_store", 32'(done_is_store), 0);
    tick(); rst = 0;
    repeat (4) begin
      @(negedge clk); check("rstreq no done", 32'(done_valid), 0);
      tick();
    end
    ack_lat = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
